// File: rtl/add_share_sched_pkg.sv
// add_share_sched_pkg: shared types and constants for the shared-adder scheduler
package add_share_sched_pkg;
  localparam int SLICE_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/add_share_sched_if.sv
// add_share_sched_if: requester/result handshake bundle; res_ovf exists only with ADD_SHARE_SCHED_OVF_EN
interface add_share_sched_if
  import add_share_sched_pkg::*;
#(parameter int WIDTH = 2 * SLICE_W);
  logic             req0_valid, req0_ready, req0_cin;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, res_sum;
  logic             res_valid, res_ready, res_cout, res_id;
`ifdef ADD_SHARE_SCHED_OVF_EN
  logic             res_ovf;
`endif
  modport master (
`ifdef ADD_SHARE_SCHED_OVF_EN
    input  res_ovf,
`endif
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin, res_ready,
    input  req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id
  );
  modport slave (
`ifdef ADD_SHARE_SCHED_OVF_EN
    output res_ovf,
`endif
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin, res_ready,
    output req0_ready, req1_ready, res_valid, res_sum, res_cout, res_id
  );
endinterface

// File: rtl/add_share_sched_carry_select.sv
// carry_select_16bit: 16-bit carry-select adder, low byte rippled, high byte precomputed for both carries
module carry_select_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);
  logic [8:0] lo, hi0, hi1;
  always_comb begin
    lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'b0, c_in};
    hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    hi1 = hi0 + 9'd1;
    {c_out, sum} = {lo[8] ? hi1 : hi0, lo[7:0]};
  end
endmodule

// File: rtl/add_share_sched.sv
// add_share_sched: round-robin scheduler feeding WORDS 16-bit slices through one shared adder.
// Define ADD_SHARE_SCHED_OVF_EN to add the registered signed-overflow output res_ovf.
module add_share_sched
  import add_share_sched_pkg::*;
#(parameter int WORDS = 2) (
  input logic              clk,
  input logic              rst,
  add_share_sched_if.slave bus
);
  localparam int WIDTH = SLICE_W * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  state_t               state_q;
  logic [IW-1:0]        idx_q;
  logic                 carry_q, last_id_q, id_q, cout_q;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic [SLICE_W-1:0]   s_sum;
  logic                 s_cout, g0, g1, hs, last;
  // requester that did not own the previous result wins a tie
  always_comb begin
    g0 = bus.req0_valid & (~bus.req1_valid | last_id_q);
    g1 = bus.req1_valid & (~bus.req0_valid | ~last_id_q);
    hs = bus.req0_ready | bus.req1_ready;
    last = idx_q == IW'(WORDS - 1);
  end
  assign bus.req0_ready = (state_q == IDLE) & g0 & ~rst;
  assign bus.req1_ready = (state_q == IDLE) & g1 & ~rst;
  carry_select_16bit u_add (
    .a(a_q[idx_q*SLICE_W +: SLICE_W]),
    .b(b_q[idx_q*SLICE_W +: SLICE_W]),
    .c_in(carry_q),
    .sum(s_sum),
    .c_out(s_cout)
  );
`ifdef ADD_SHARE_SCHED_OVF_EN
  logic ovf_q;
  assign bus.res_ovf = ovf_q;
  always_ff @(posedge clk)
    if (rst) ovf_q <= 1'b0;
    else if (state_q == RUN && last)
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (s_sum[SLICE_W-1] != a_q[WIDTH-1]);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      last_id_q <= 1'b1;
      id_q      <= 1'b0;
      cout_q    <= 1'b0;
      sum_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (hs) begin
          a_q     <= g0 ? bus.req0_a : bus.req1_a;
          b_q     <= g0 ? bus.req0_b : bus.req1_b;
          carry_q <= g0 ? bus.req0_cin : bus.req1_cin;
          id_q    <= ~g0;
          idx_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          sum_q[idx_q*SLICE_W +: SLICE_W] <= s_sum;
          carry_q <= s_cout;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            state_q   <= DONE;
            cout_q    <= s_cout;
            last_id_q <= id_q;
          end
        end
        DONE: if (bus.res_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.res_valid = state_q == DONE;
  assign bus.res_sum   = sum_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;
endmodule

// File: tb/tb_add_share_sched.sv
// tb_add_share_sched: table vectors, hand sequences and a randomized model check of add_share_sched (WORDS=2)
module tb_add_share_sched;
  localparam int WORDS = 2;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  add_share_sched_if #(.WIDTH(W)) bus();
  add_share_sched #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int last_served = 1;
  typedef struct {
    int          id;
    logic [W-1:0] a, b;
    logic        cin;
    logic [W-1:0] sum;
    logic        cout, ovf;
    int          stall;
  } vec_t;
  vec_t tbl[7];
  logic         pend[2];
  logic [W-1:0] ra[2], rb[2];
  logic         rc[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end
  endtask

  function automatic int grant_of(input logic v0, input logic v1, input int last);
    return (v0 && v1) ? 1 - last : (v0 ? 0 : 1);
  endfunction

  function automatic logic ovf_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  // call from IDLE with the requesters already driven and settled
  task automatic run_op(input int exp_id, input logic [W:0] exp, input logic exp_ovf, input int stall, input logic keep);
    int n;
    chk("grant_ready0", bus.req0_ready, exp_id == 0);
    chk("grant_ready1", bus.req1_ready, exp_id == 1);
    bus.res_ready = (stall == 0);
    step;
    if (!keep) begin
      if (exp_id == 0) bus.req0_valid = 1'b0;
      else bus.req1_valid = 1'b0;
    end
    n = 1;
    while (!bus.res_valid && n < 20) begin
      chk("run_ready", {bus.req0_ready, bus.req1_ready}, 0);
      step;
      n++;
    end
    chk("latency", n, WORDS + 1);
    for (int s = 0; s <= stall; s++) begin
      chk("res_valid", bus.res_valid, 1);
      chk("res_sum", bus.res_sum, exp[W-1:0]);
      chk("res_cout", bus.res_cout, exp[W]);
      chk("res_id", bus.res_id, exp_id);
`ifdef ADD_SHARE_SCHED_OVF_EN
      chk("res_ovf", bus.res_ovf, exp_ovf);
`endif
      chk("done_ready", {bus.req0_ready, bus.req1_ready}, 0);
      if (s < stall) step;
      if (s == stall - 1) begin
        bus.res_ready = 1'b1;
        #1;
      end
    end
    step;
    chk("res_valid_drop", bus.res_valid, 0);
    last_served = exp_id;
  endtask

  initial begin
    tbl[0] = '{0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 0};
    tbl[1] = '{1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0};
    tbl[2] = '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 2};
    tbl[3] = '{1, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0, 5};
    tbl[4] = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1};
    tbl[5] = '{1, 32'h0000FFFF, 32'h00000000, 1'b1, 32'h00010000, 1'b0, 1'b0, 0};
    tbl[6] = '{0, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 1'b1, 1'b0, 3};
    drive(0, 1'b1, 32'h00010001, 32'h0000FFFF, 1'b0);
    drive(1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    bus.res_ready = 1'b1;
    step;
    step;
    chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_sum", bus.res_sum, 0);
    chk("rst_cout", bus.res_cout, 0);
    chk("rst_id", bus.res_id, 0);
`ifdef ADD_SHARE_SCHED_OVF_EN
    chk("rst_ovf", bus.res_ovf, 0);
`endif
    rst = 1'b0;
    #1;
    // both requesters valid continuously: grants must alternate starting at 0
    for (int k = 0; k < 8; k++)
      run_op(k % 2, (k % 2 == 0) ? 33'h0_00020000 : 33'h1_FFFFFFFF, 1'b0, 0, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].id, 1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
      #1;
      run_op(tbl[i].id, {tbl[i].cout, tbl[i].sum}, tbl[i].ovf, tbl[i].stall, 1'b0);
    end
    // reset during RUN discards the op
    drive(0, 1'b1, 32'hAAAA5555, 32'h5555AAAA, 1'b1);
    #1;
    chk("mid_rst_ready0", bus.req0_ready, 1);
    step;
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    last_served = 1;
    for (int k = 0; k < 4; k++) begin
      chk("mid_rst_no_result", bus.res_valid, 0);
      step;
    end
    drive(1, 1'b1, 32'h12345678, 32'h11111111, 1'b0);
    #1;
    run_op(1, 33'h0_23456789, 1'b0, 0, 1'b0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [W:0] exp;
      int g;
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r] = 1'b1;
          ra[r] = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
          rb[r] = ($urandom_range(0, 5) == 0) ? 32'h00000001 : $urandom;
          rc[r] = 1'($urandom_range(0, 1));
        end
      if (!pend[0] && !pend[1]) begin
        g = $urandom_range(0, 1);
        pend[g] = 1'b1; ra[g] = $urandom; rb[g] = $urandom; rc[g] = 1'b0;
      end
      for (int r = 0; r < 2; r++) drive(r, pend[r], ra[r], rb[r], rc[r]);
      #1;
      g = grant_of(pend[0], pend[1], last_served);
      exp = {1'b0, ra[g]} + {1'b0, rb[g]} + {32'b0, rc[g]};
      run_op(g, exp, ovf_of(ra[g], rb[g], exp[W-1:0]), $urandom_range(0, 3), 1'b0);
      pend[g] = 1'b0;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
